serial_pattern_source: RTL and testbench

Upstream stage for the serial run-length detector: accepts a parallel test word through a valid/ready handshake and emits it MSB-first as a 1-bit stream, one bit every DIV clocks. It drives the detector's serial input. It turns switch or bus words into a deterministic bit sequence, so detector behaviour can be exercised and observed on the board.

---
 rtl/serial_pkg.sv | 34 +++
 rtl/serial_pattern_source_bit_tick_gen.sv | 52 +++++
 rtl/serial_pattern_source.sv | 131 +++++++++++++
 tb/tb_serial_pattern_source.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial pattern source: state encoding,
// default geometry and the keyed next-state selector.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIV   = 4;
    localparam int TIMER_W       = 8;
    localparam int IDX_W         = 4;

    // Keyed selector: picks the candidate for the current state and falls
    // back to IDLE for any encoding outside the three legal states.
    function automatic state_e mux_key_with_default(
        input state_e key,
        input state_e idle_v,
        input state_e shift_v,
        input state_e done_v
    );
        state_e sel;
        case (key)
            IDLE:    sel = idle_v;
            SHIFT:   sel = shift_v;
            DONE:    sel = done_v;
            default: sel = IDLE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/serial_pattern_source_bit_tick_gen.sv
// Bit-period timer: counts clocks while the stream is running, stalls on
// hold, and flags the last clock of each bit period with a one-cycle tick.
module bit_tick_gen
    import serial_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic run,
    input  logic hold,
    output logic tick
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(DIV - 1);

    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;

    // Tick marks the final clock of a bit period; a held cycle never ticks.
    always_comb begin
        tick = run && !hold && (timer_q == LAST);
    end

    // Timer next value: cleared on start or when idle, frozen on hold,
    // wraps to zero after DIV-1 and never counts beyond it.
    always_comb begin
        timer_d = timer_q;
        if (start) begin
            timer_d = {TIMER_W{1'b0}};
        end else if (!run) begin
            timer_d = {TIMER_W{1'b0}};
        end else if (hold) begin
            timer_d = timer_q;
        end else if (timer_q == LAST) begin
            timer_d = {TIMER_W{1'b0}};
        end else begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    // Timer register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= {TIMER_W{1'b0}};
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/serial_pattern_source.sv
// Serial pattern source: accepts a parallel word over valid/ready and
// replays it MSB-first on a 1-bit output, each bit held for DIV clocks.
module serial_pattern_source
    import serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIV   = DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             hold,
    output logic             out,
    output logic             out_valid,
    output logic [IDX_W-1:0] bit_idx,
    output logic             done
);

    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(WIDTH - 1);

    state_e             state_q,      state_d;
    logic [WIDTH-1:0]   shreg_q,      shreg_d;
    logic [IDX_W-1:0]   bit_idx_q,    bit_idx_d;
    logic               out_q,        out_d;
    logic               out_valid_q,  out_valid_d;
    logic               done_q,       done_d;
    logic               load_ready_q, load_ready_d;

    logic               accept_s;
    logic               run_s;
    logic               tick_s;
    logic               last_bit_s;
    state_e             idle_next_s;
    state_e             shift_next_s;

    bit_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .start (accept_s),
        .run   (run_s),
        .hold  (hold),
        .tick  (tick_s)
    );

    // Handshake and per-state events feeding the keyed next-state selector.
    always_comb begin
        accept_s     = (state_q == IDLE) && load_ready_q && load_valid;
        run_s        = (state_q == SHIFT);
        last_bit_s   = (bit_idx_q == {IDX_W{1'b0}});
        idle_next_s  = accept_s ? SHIFT : IDLE;
        shift_next_s = (tick_s && last_bit_s) ? DONE : SHIFT;
        state_d      = mux_key_with_default(state_q, idle_next_s, shift_next_s, IDLE);
    end

    // Datapath and output next values; `out` always mirrors the MSB of the
    // shift register so it keeps the last bit while idle.
    always_comb begin
        shreg_d      = shreg_q;
        bit_idx_d    = bit_idx_q;
        out_valid_d  = out_valid_q;
        done_d       = 1'b0;
        load_ready_d = load_ready_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    shreg_d      = load_data;
                    bit_idx_d    = TOP_IDX;
                    out_valid_d  = 1'b1;
                    load_ready_d = 1'b0;
                end else begin
                    out_valid_d  = 1'b0;
                    load_ready_d = 1'b1;
                end
            end
            SHIFT: begin
                load_ready_d = 1'b0;
                if (tick_s && last_bit_s) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                end else if (tick_s) begin
                    shreg_d     = {shreg_q[WIDTH-2:0], 1'b0};
                    bit_idx_d   = bit_idx_q - IDX_W'(1);
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                out_valid_d  = 1'b0;
                load_ready_d = 1'b1;
            end
            default: begin
                out_valid_d  = 1'b0;
                load_ready_d = 1'b1;
            end
        endcase
        out_d = shreg_d[WIDTH-1];
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shreg_q      <= {WIDTH{1'b0}};
            bit_idx_q    <= {IDX_W{1'b0}};
            out_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            load_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_idx_q    <= bit_idx_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
            load_ready_q <= load_ready_d;
        end
    end

    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign bit_idx    = bit_idx_q;
    assign done       = done_q;
    assign load_ready = load_ready_q;

endmodule

// File: tb/tb_serial_pattern_source.sv
// Bench for serial_pattern_source: three instances (DIV = 1, 2, 4) checked
// cycle by cycle against a stream model built from the word and hold pattern.
module tb_serial_pattern_source;

    localparam int W  = 8;
    localparam int NI = 3;

    logic         clk = 1'b0;
    logic         rst  [NI];
    logic         lv   [NI];
    logic         hold [NI];
    logic [W-1:0] ld   [NI];
    logic         lr   [NI];
    logic         o    [NI];
    logic         ov   [NI];
    logic         dn   [NI];
    logic [3:0]   bi   [NI];
    logic         last_out [NI];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        serial_pattern_source #(
            .WIDTH (W),
            .DIV   ((g == 0) ? 1 : ((g == 1) ? 2 : 4))
        ) u_dut (
            .clk        (clk),
            .reset      (rst[g]),
            .load_valid (lv[g]),
            .load_ready (lr[g]),
            .load_data  (ld[g]),
            .hold       (hold[g]),
            .out        (o[g]),
            .out_valid  (ov[g]),
            .bit_idx    (bi[g]),
            .done       (dn[g])
        );
    end

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    // observed = {out, out_valid, bit_idx, done, load_ready}
    function automatic logic [7:0] obs(input int i);
        return {o[i], ov[i], bi[i], dn[i], lr[i]};
    endfunction

    // Model: the nominal stream is W*DIV slots, slot p carrying bit
    // W-1-p/DIV. A hold cycle repeats the current slot. After the last slot
    // comes one done cycle, then idle with load_ready high.
    task automatic run_word(input int inst, input logic [W-1:0] word, input int hold_mode,
                            input bit keep_valid, input logic [W-1:0] next_word,
                            output longint t_acc, output int done_cyc);
        int         d;
        int         total;
        int         pos;
        int         held;
        int         bitn;
        bit         fin;
        logic       hb;
        logic [7:0] exp;
        d        = div_of(inst);
        total    = W * d;
        pos      = 0;
        held     = 0;
        fin      = 1'b0;
        done_cyc = -1;
        vectors++;
        exp = {last_out[inst], 1'b0, 4'd0, 1'b0, 1'b1};
        if (obs(inst) !== exp) begin
            miscompares++;
            $display("FAIL pre_accept inst=%0d got=%b want=%b", inst, obs(inst), exp);
        end
        lv[inst]   = 1'b1;
        ld[inst]   = word;
        hold[inst] = 1'b0;
        @(posedge clk);
        t_acc = $time;
        for (int c = 1; c <= 400 && !fin; c++) begin
            @(negedge clk);
            hb = 1'b0;
            if (pos < total) begin
                bitn = W - 1 - pos / d;
                exp  = {word[bitn], 1'b1, 4'(bitn), 1'b0, 1'b0};
                if (hold_mode == 1) begin
                    hb = ($urandom_range(0, 3) == 0);
                end else if (hold_mode == 2) begin
                    hb = (pos == 4 && held < 3);
                end
                if (hb) held++;
            end else if (pos == total) begin
                exp      = {word[0], 1'b0, 4'd0, 1'b1, 1'b0};
                done_cyc = c;
                hb       = (hold_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end else begin
                exp = {word[0], 1'b0, 4'd0, 1'b0, 1'b1};
                fin = 1'b1;
            end
            vectors++;
            if (obs(inst) !== exp) begin
                miscompares++;
                $display("FAIL stream inst=%0d word=%h cyc=%0d got=%b want=%b",
                         inst, word, c, obs(inst), exp);
            end
            hold[inst] = hb;
            if (fin) begin
                lv[inst]   = keep_valid;
                ld[inst]   = next_word;
                hold[inst] = 1'b0;
            end else if (keep_valid) begin
                lv[inst] = 1'b1;
                ld[inst] = next_word;
            end else begin
                lv[inst] = 1'($urandom_range(0, 1));
                ld[inst] = W'($urandom);
            end
            if (!(pos < total && hb)) pos++;
        end
        last_out[inst] = word[0];
    endtask

    task automatic check_idle(input int inst, input string name);
        logic [7:0] exp;
        exp = {last_out[inst], 1'b0, 4'd0, 1'b0, 1'b1};
        vectors++;
        if (obs(inst) !== exp) begin
            miscompares++;
            $display("FAIL %s inst=%0d got=%b want=%b", name, inst, obs(inst), exp);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NI; i++) begin
            rst[i] = 1'b1; lv[i] = 1'b0; hold[i] = 1'b0; ld[i] = '0; last_out[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        for (int i = 0; i < NI; i++) check_idle(i, "reset_state");
    endtask

    task automatic test_div1_a5();
        longint t; int dc;
        run_word(0, 8'hA5, 0, 1'b0, 8'h00, t, dc);
        vectors++;
        if (dc !== 9) begin
            miscompares++;
            $display("FAIL div1_done_cycle got=%0d want=9", dc);
        end
    endtask

    task automatic test_div4_f0();
        longint t; int dc;
        run_word(2, 8'hF0, 0, 1'b0, 8'h00, t, dc);
        vectors++;
        if (dc !== 33) begin
            miscompares++;
            $display("FAIL div4_done_cycle got=%0d want=33", dc);
        end
    endtask

    task automatic test_hold();
        longint t; int dc;
        run_word(1, 8'hFF, 2, 1'b0, 8'h00, t, dc);
        vectors++;
        if (dc !== 20) begin
            miscompares++;
            $display("FAIL hold_done_cycle got=%0d want=20", dc);
        end
    endtask

    task automatic test_back_to_back();
        longint t1, t2; int dc; int gap;
        run_word(1, 8'h0F, 0, 1'b1, 8'hF0, t1, dc);
        run_word(1, 8'hF0, 0, 1'b0, 8'h00, t2, dc);
        gap = int'((t2 - t1) / 10);
        vectors++;
        if (gap !== 18) begin
            miscompares++;
            $display("FAIL b2b_interval got=%0d want=18", gap);
        end
    endtask

    task automatic test_reset_mid();
        longint t; int dc;
        logic [W-1:0] w;
        w = W'($urandom);
        lv[2] = 1'b1; ld[2] = w;
        @(posedge clk);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            lv[2] = 1'b0;
            if (c == 18) begin
                vectors++;
                if (bi[2] !== 4'd3) begin
                    miscompares++;
                    $display("FAIL reset_mid_idx got=%0d want=3", bi[2]);
                end
                rst[2] = 1'b1;
            end
        end
        @(negedge clk);
        rst[2]      = 1'b0;
        last_out[2] = 1'b0;
        for (int c = 0; c < 40; c++) begin
            check_idle(2, "reset_mid_quiet");
            @(negedge clk);
        end
        run_word(2, W'($urandom), 1, 1'b0, 8'h00, t, dc);
    endtask

    task automatic test_reset_with_load();
        rst[0] = 1'b1; lv[0] = 1'b1; ld[0] = W'($urandom) | 8'h80;
        @(negedge clk);
        rst[0] = 1'b0; lv[0] = 1'b0;
        last_out[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check_idle(0, "reset_with_load");
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        longint t; int dc; int inst;
        for (int k = 0; k < 8; k++) begin
            inst = $urandom_range(0, NI - 1);
            run_word(inst, W'($urandom), 1, 1'b0, 8'h00, t, dc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_div1_a5();
        test_div4_f0();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_reset_with_load();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
